// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard and a sequential clear engine.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1Data,
  output logic [XLEN-1:0] rs2Data,
  output logic            rs1Busy,
  output logic            rs2Busy,
  input  logic            writeEnable,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] data,
  input  logic            issueEnable,
  input  logic [AW-1:0]   issueRd,
  input  logic            clearReq,
  output logic            ready
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              clear_go, do_wr, do_iss;

  assign ready    = (state == READY);
  assign clear_go = ready & clearReq;
  // clearReq outranks any same-cycle write/issue
  assign do_wr    = ready & ~clearReq & writeEnable & (rd != '0);
  assign do_iss   = ready & ~clearReq & issueEnable & (issueRd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= AW'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(NREGS-1)) state_nxt = READY;
      end
      READY: begin
        if (clearReq) begin
          state_nxt = CLEAR;
          cnt_nxt   = AW'(1);
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Issue is applied after write so a same-register collision leaves busy set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (clear_go) begin
      busy <= '0;
    end else begin
      if (do_wr)  busy[rd]      <= 1'b0;
      if (do_iss) busy[issueRd] <= 1'b1;
    end
  end

  // Array contents are zeroed only by the clear walk, never by reset
  always_ff @(posedge clk) begin
    if (state == CLEAR)  regs[cnt] <= '0;
    else if (do_wr)      regs[rd]  <= data;
  end

  logic [1:0][AW-1:0]   ra;
  logic [1:0][XLEN-1:0] rdat;
  logic [1:0]           rbsy;

  assign ra      = {rs2, rs1};
  assign rs1Data = rdat[0];
  assign rs2Data = rdat[1];
  assign rs1Busy = rbsy[0];
  assign rs2Busy = rbsy[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdat[p] = '0;
      rbsy[p] = 1'b0;
      if (ready && ra[p] != '0) begin
        rdat[p] = regs[ra[p]];
        rbsy[p] = busy[ra[p]];
`ifdef REGFILE_BYPASS_EN
        if (writeEnable && rd != '0 && rd == ra[p]) begin
          rdat[p] = data;
          rbsy[p] = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (NREGS=32, XLEN=32).
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1, rs2, rd, issueRd;
  logic [XLEN-1:0] rs1Data, rs2Data, data;
  logic            rs1Busy, rs2Busy, writeEnable, issueEnable, clearReq, ready;

  int tests = 0;
  int fails = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1(rs1), .rs2(rs2), .rs1Data(rs1Data), .rs2Data(rs2Data),
    .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
    .writeEnable(writeEnable), .rd(rd), .data(data),
    .issueEnable(issueEnable), .issueRd(issueRd),
    .clearReq(clearReq), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_all_zero(input string name);
    int bad = 0;
    for (int i = 0; i < NREGS; i++) begin
      rs1 = AW'(i);
      rs2 = AW'(NREGS - 1 - i);
      #1;
      if (rs1Data !== '0 || rs1Busy !== 1'b0 || rs2Data !== '0 || rs2Busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d nonzero reads, required 0", name, bad);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; issueRd = '0; data = '0;
    writeEnable = 1'b0; issueEnable = 1'b0; clearReq = 1'b0;
    tick(); tick();
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready); end
    rst_n = 1'b1;
    wait_ready(n);
    tests++;
    if (n != 31) begin fails++; $display("FAIL reset_clear_len: got %0d cycles want 31", n); end
    check_all_zero("reset_contents");
  endtask

  task automatic test_write();
    writeEnable = 1'b1; rd = 5'd5; data = 32'hDEADBEEF;
    tick();
    writeEnable = 1'b0; rs1 = 5'd5; #1;
    tests++;
    if (rs1Data !== 32'hDEADBEEF) begin fails++; $display("FAIL write_r5: got %h want deadbeef", rs1Data); end
    writeEnable = 1'b1; rd = 5'd0; data = 32'h1;
    tick();
    writeEnable = 1'b0; rs2 = 5'd0; #1;
    tests++;
    if (rs2Data !== '0 || rs2Busy !== 1'b0) begin
      fails++; $display("FAIL write_r0: got %h/%b want 0/0", rs2Data, rs2Busy);
    end
  endtask

  task automatic test_scoreboard();
    issueEnable = 1'b1; issueRd = 5'd7;
    tick();
    issueEnable = 1'b0; rs1 = 5'd7; #1;
    tests++;
    if (rs1Busy !== 1'b1) begin fails++; $display("FAIL issue_r7: busy got %b want 1", rs1Busy); end
    writeEnable = 1'b1; rd = 5'd7; data = 32'h12;
    tick();
    writeEnable = 1'b0; #1;
    tests++;
    if (rs1Busy !== 1'b0 || rs1Data !== 32'h12) begin
      fails++; $display("FAIL writeback_r7: got %b/%h want 0/00000012", rs1Busy, rs1Data);
    end
    writeEnable = 1'b1; rd = 5'd9; data = 32'h99;
    issueEnable = 1'b1; issueRd = 5'd9;
    tick();
    writeEnable = 1'b0; issueEnable = 1'b0; rs1 = 5'd9; #1;
    tests++;
    if (rs1Busy !== 1'b1 || rs1Data !== 32'h99) begin
      fails++; $display("FAIL issue_write_r9: got %b/%h want 1/00000099", rs1Busy, rs1Data);
    end
    issueEnable = 1'b1; issueRd = 5'd0;
    tick();
    issueEnable = 1'b0; rs2 = 5'd0; #1;
    tests++;
    if (rs2Busy !== 1'b0) begin fails++; $display("FAIL issue_r0: busy got %b want 0", rs2Busy); end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hA5A5A5A5;
`else
    exp = 32'h0;
`endif
    rs2 = 5'd3; writeEnable = 1'b1; rd = 5'd3; data = 32'hA5A5A5A5; #1;
    tests++;
    if (rs2Data !== exp || rs2Busy !== 1'b0) begin
      fails++; $display("FAIL bypass_r3: got %h/%b want %h/0", rs2Data, rs2Busy, exp);
    end
    tick();
    writeEnable = 1'b0; #1;
    tests++;
    if (rs2Data !== 32'hA5A5A5A5) begin fails++; $display("FAIL after_bypass_r3: got %h want a5a5a5a5", rs2Data); end
  endtask

  task automatic test_clear();
    int n;
    issueEnable = 1'b1; issueRd = 5'd10;
    tick();
    // clear with simultaneous write and issue: both must be dropped
    issueEnable = 1'b1; issueRd = 5'd11;
    writeEnable = 1'b1; rd = 5'd12; data = 32'h77;
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0; issueEnable = 1'b0;
    rs1 = 5'd5; #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL clear_ready_drop: got %b want 0", ready); end
    tests++;
    if (rs1Data !== '0) begin fails++; $display("FAIL clear_read_forced: got %h want 0", rs1Data); end
    // writes held and clearReq re-asserted during CLEAR must have no effect
    writeEnable = 1'b1; rd = 5'd5; data = 32'hFFFF; clearReq = 1'b1;
    tick(); tick();
    clearReq = 1'b0;
    wait_ready(n);
    writeEnable = 1'b0;
    tests++;
    if (n != 29) begin fails++; $display("FAIL clear_len: got %0d cycles want 29 after first two", n); end
    check_all_zero("clear_contents");
  endtask

  task automatic test_reset_mid_clear();
    int n;
    writeEnable = 1'b1; rd = 5'd20; data = 32'hCAFEF00D;
    tick();
    writeEnable = 1'b0; rs1 = 5'd20; #1;
    tests++;
    if (rs1Data !== 32'hCAFEF00D) begin fails++; $display("FAIL load_r20: got %h want cafef00d", rs1Data); end
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0; #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL midclear_rst_ready: got %b want 0", ready); end
    #1 rst_n = 1'b1;
    wait_ready(n);
    tests++;
    if (n != 31) begin fails++; $display("FAIL midclear_restart_len: got %0d cycles want 31", n); end
    check_all_zero("midclear_contents");
    // reset from READY drops ready without waiting for an edge
    issueEnable = 1'b1; issueRd = 5'd4;
    tick();
    issueEnable = 1'b0;
    rst_n = 1'b0; #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL ready_rst_async: got %b want 0", ready); end
    #1 rst_n = 1'b1;
    wait_ready(n);
    tests++;
    if (n != 31) begin fails++; $display("FAIL ready_rst_len: got %0d cycles want 31", n); end
    rs1 = 5'd4; #1;
    tests++;
    if (rs1Busy !== 1'b0) begin fails++; $display("FAIL rst_busy_r4: got %b want 0", rs1Busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_scoreboard();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=4); AW = log2(NREGS) is derived, not a port.
REQ-003 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: rs1, rs2  in  AW  read addresses; rs1Data, rs2Data  out  XLEN  read data.
REQ-006 SHALL have ports: rs1Busy, rs2Busy  out  1  pending-write flag of addressed register.
REQ-007 SHALL have ports: writeEnable  in  1; rd  in  AW; data  in  XLEN  write port.
REQ-008 SHALL have ports: issueEnable  in  1; issueRd  in  AW  marks issueRd busy (producer issued).
REQ-009 SHALL have ports: clearReq  in  1  request full register/scoreboard clear; ready  out  1  block accepting writes/issues.

Function
REQ-010 SHALL keep register 0 hardwired: reads return 0, writes and issues to it ignored, busy always 0.
REQ-011 SHALL perform writes on rising clk edge when writeEnable=1, ready=1, rd!=0; write also clears busy[rd].
REQ-012 SHALL provide combinational reads: rsXData = registers[rsX], rsXBusy = busy[rsX], zero latency.
REQ-013 SHALL set busy[issueRd] on rising edge when issueEnable=1, ready=1, issueRd!=0.
REQ-014 SHALL, when write and issue target same register in one cycle, store data and leave busy=1 (issue wins).
REQ-015 SHALL implement FSM with states CLEAR and READY; ready=1 only in READY.
REQ-016 SHALL, in CLEAR, zero one register per cycle via counter from 1 to NREGS-1, then enter READY on the cycle after index NREGS-1 is cleared (NREGS-1 cycles in CLEAR).
REQ-017 SHALL clear all busy bits on entry to CLEAR.
REQ-018 SHALL, in CLEAR, ignore writeEnable and issueEnable and force rs1Data, rs2Data, rs1Busy, rs2Busy to 0.
REQ-019 SHALL move READY->CLEAR on rising edge with clearReq=1; clearReq in CLEAR is ignored (no restart).
REQ-020 SHALL give clearReq priority over a same-cycle write/issue (those are dropped).

Reset
REQ-021 SHALL, on rst_n=0, asynchronously set state=CLEAR, counter=1, all busy bits=0; ready=0 immediately.
REQ-022 SHALL, on rst_n deassertion, run the CLEAR sequence of REQ-016 from index 1.
REQ-023 SHALL restart the CLEAR sequence from index 1 if rst_n asserts mid-clear or in READY.
REQ-024 SHALL not require register array contents reset asynchronously; zeroing done by CLEAR only.

Configuration
REQ-025 SHALL support macro REGFILE_BYPASS_EN.
REQ-026 SHALL, with REGFILE_BYPASS_EN defined and ready=1, return data on rsXData and 0 on rsXBusy when writeEnable=1, rd!=0, rd==rsX in the same cycle (write-to-read forwarding).
REQ-027 SHALL, without REGFILE_BYPASS_EN, return old register contents and current busy state until the edge after the write.

Verification
REQ-028 SHALL cover: reset release -> ready=0 for 31 cycles (NREGS=32), then ready=1; all reads 0, all busy 0.
REQ-029 SHALL cover: write rd=5 data=0xDEADBEEF, next cycle rs1=5 -> rs1Data=0xDEADBEEF; write rd=0 data=0x1 -> rs2=0 reads 0.
REQ-030 SHALL cover: issue rd=7, next cycle rs1=7 -> rs1Busy=1; write rd=7 data=0x12 -> next cycle rs1Busy=0, rs1Data=0x12; same-cycle issue+write rd=9 -> busy=1, data stored.
REQ-031 SHALL cover: REGFILE_BYPASS_EN defined, write rd=3 data=0xA5A5A5A5 with rs2=3 same cycle -> rs2Data=0xA5A5A5A5, rs2Busy=0; undefined -> old value 0.
REQ-032 SHALL cover: clearReq with registers loaded -> ready drops next cycle, writes during CLEAR ignored, after 31 cycles all registers 0; rst_n pulse at clear index 10 -> sequence restarts, full 31 cycles.
